// File: rtl/system_controller_axil_regs.sv
// AXI4-Lite slave exposing four 32-bit control registers (reg0..reg3) to the
// controller fabric, with a per-register write pulse.
// Optional feature: define SYSTEM_CONTROLLER_SLVERR_EN to answer accesses to
// unmapped offsets (0x10-0x1C) with SLVERR instead of OKAY.
module system_controller_axil_regs #(
  parameter int C_S00_AXI_DATA_WIDTH = 32,
  parameter int C_S00_AXI_ADDR_WIDTH = 5
) (
  input  logic                                s00_axi_aclk,
  input  logic                                s00_axi_areset,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
  input  logic [2:0]                          s00_axi_awprot,
  input  logic                                s00_axi_awvalid,
  output logic                                s00_axi_awready,
  input  logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
  input  logic [C_S00_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
  input  logic                                s00_axi_wvalid,
  output logic                                s00_axi_wready,
  output logic [1:0]                          s00_axi_bresp,
  output logic                                s00_axi_bvalid,
  input  logic                                s00_axi_bready,
  input  logic [C_S00_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
  input  logic [2:0]                          s00_axi_arprot,
  input  logic                                s00_axi_arvalid,
  output logic                                s00_axi_arready,
  output logic [C_S00_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
  output logic [1:0]                          s00_axi_rresp,
  output logic                                s00_axi_rvalid,
  input  logic                                s00_axi_rready,
  output logic [C_S00_AXI_DATA_WIDTH-1:0]     reg0,
  output logic [C_S00_AXI_DATA_WIDTH-1:0]     reg1,
  output logic [C_S00_AXI_DATA_WIDTH-1:0]     reg2,
  output logic [C_S00_AXI_DATA_WIDTH-1:0]     reg3,
  output logic [3:0]                          reg_wr_pulse
);

  localparam int DW = C_S00_AXI_DATA_WIDTH;
  localparam int SW = C_S00_AXI_DATA_WIDTH / 8;
  localparam int AW = C_S00_AXI_ADDR_WIDTH;

  localparam logic [1:0] RESP_OKAY = 2'b00;
`ifdef SYSTEM_CONTROLLER_SLVERR_EN
  localparam logic [1:0] RESP_UNMAPPED = 2'b10;
`else
  localparam logic [1:0] RESP_UNMAPPED = 2'b00;
`endif

  // Merge new data into the old word, byte lane by byte lane.
  function automatic logic [DW-1:0] apply_strb(input logic [DW-1:0] old_v,
                                               input logic [DW-1:0] new_v,
                                               input logic [SW-1:0] strb);
    logic [DW-1:0] res;
    res = old_v;
    for (int i = 0; i < SW; i++) begin
      if (strb[i]) res[8*i +: 8] = new_v[8*i +: 8];
    end
    return res;
  endfunction

  // Only the first 16 bytes of the window carry registers.
  function automatic logic is_mapped(input logic [AW-1:0] a);
    return a[AW-1:4] == '0;
  endfunction

  logic          aw_held_q, aw_held_d;
  logic [AW-1:0] aw_addr_q, aw_addr_d;
  logic          w_held_q,  w_held_d;
  logic [DW-1:0] w_data_q,  w_data_d;
  logic [SW-1:0] w_strb_q,  w_strb_d;
  logic          bvalid_q,  bvalid_d;
  logic [1:0]    bresp_q,   bresp_d;
  logic          rvalid_q,  rvalid_d;
  logic [DW-1:0] rdata_q,   rdata_d;
  logic [1:0]    rresp_q,   rresp_d;
  logic [3:0]    pulse_q,   pulse_d;
  logic [DW-1:0] reg_q [4];
  logic [DW-1:0] reg_d [4];

  logic          aw_hs, w_hs, ar_hs;
  logic [1:0]    wr_idx, rd_idx;
  logic          unused_bits;

  // A channel is accepted only while it is empty and no response is pending;
  // readies are forced low during reset.
  assign s00_axi_awready = s00_axi_awvalid & ~aw_held_q & ~bvalid_q & ~s00_axi_areset;
  assign s00_axi_wready  = s00_axi_wvalid  & ~w_held_q  & ~bvalid_q & ~s00_axi_areset;
  assign s00_axi_arready = s00_axi_arvalid & ~rvalid_q & ~s00_axi_areset;

  assign aw_hs  = s00_axi_awready;
  assign w_hs   = s00_axi_wready;
  assign ar_hs  = s00_axi_arready;
  assign wr_idx = aw_addr_q[3:2];
  assign rd_idx = s00_axi_araddr[3:2];

  assign s00_axi_bvalid = bvalid_q;
  assign s00_axi_bresp  = bresp_q;
  assign s00_axi_rvalid = rvalid_q;
  assign s00_axi_rdata  = rdata_q;
  assign s00_axi_rresp  = rresp_q;
  assign reg0           = reg_q[0];
  assign reg1           = reg_q[1];
  assign reg2           = reg_q[2];
  assign reg3           = reg_q[3];
  assign reg_wr_pulse   = pulse_q;

  // Protection bits and the byte offset within a word carry no meaning here.
  assign unused_bits = ^{s00_axi_awprot, s00_axi_arprot, aw_addr_q[1:0], s00_axi_araddr[1:0]};

  // Next-state for the write holds, write commit, response and read return.
  always_comb begin
    aw_held_d = aw_held_q;
    aw_addr_d = aw_addr_q;
    w_held_d  = w_held_q;
    w_data_d  = w_data_q;
    w_strb_d  = w_strb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    rvalid_d  = rvalid_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    pulse_d   = '0;
    for (int i = 0; i < 4; i++) reg_d[i] = reg_q[i];

    if (aw_hs) begin
      aw_held_d = 1'b1;
      aw_addr_d = s00_axi_awaddr;
    end
    if (w_hs) begin
      w_held_d = 1'b1;
      w_data_d = s00_axi_wdata;
      w_strb_d = s00_axi_wstrb;
    end

    // Both halves present: commit and raise the response in the same edge.
    if (aw_held_q && w_held_q) begin
      aw_held_d = 1'b0;
      w_held_d  = 1'b0;
      bvalid_d  = 1'b1;
      if (is_mapped(aw_addr_q)) begin
        reg_d[wr_idx]   = apply_strb(reg_q[wr_idx], w_data_q, w_strb_q);
        pulse_d[wr_idx] = 1'b1;
        bresp_d         = RESP_OKAY;
      end else begin
        bresp_d = RESP_UNMAPPED;
      end
    end else if (bvalid_q && s00_axi_bready) begin
      bvalid_d = 1'b0;
    end

    // Reads sample the current register value, so a same-edge commit is not seen.
    if (ar_hs) begin
      rvalid_d = 1'b1;
      if (is_mapped(s00_axi_araddr)) begin
        rdata_d = reg_q[rd_idx];
        rresp_d = RESP_OKAY;
      end else begin
        rdata_d = '0;
        rresp_d = RESP_UNMAPPED;
      end
    end else if (rvalid_q && s00_axi_rready) begin
      rvalid_d = 1'b0;
    end
  end

  // State registers; reset drops any half-captured write.
  always_ff @(posedge s00_axi_aclk or posedge s00_axi_areset) begin
    if (s00_axi_areset) begin
      aw_held_q <= 1'b0;
      aw_addr_q <= '0;
      w_held_q  <= 1'b0;
      w_data_q  <= '0;
      w_strb_q  <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      pulse_q   <= '0;
      for (int i = 0; i < 4; i++) reg_q[i] <= '0;
    end else begin
      aw_held_q <= aw_held_d;
      aw_addr_q <= aw_addr_d;
      w_held_q  <= w_held_d;
      w_data_q  <= w_data_d;
      w_strb_q  <= w_strb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
      pulse_q   <= pulse_d;
      for (int i = 0; i < 4; i++) reg_q[i] <= reg_d[i];
    end
  end

endmodule

// File: tb/tb_system_controller_axil_regs.sv
// Randomized bench for system_controller_axil_regs with a word-array model.
// Honours SYSTEM_CONTROLLER_SLVERR_EN for the expected unmapped response.
module tb_system_controller_axil_regs;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [4:0]  awaddr = '0, araddr = '0;
  logic [2:0]  awprot = '0, arprot = '0;
  logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        awready, wready, bvalid, arready, rvalid;
  logic [1:0]  bresp, rresp;
  logic [31:0] rdata, r0, r1, r2, r3;
  logic [3:0]  pulse;

  int n_tests = 0;
  int n_fail  = 0;
  logic [31:0] model_regs [4];

`ifdef SYSTEM_CONTROLLER_SLVERR_EN
  localparam logic [1:0] EXP_UNMAPPED = 2'b10;
`else
  localparam logic [1:0] EXP_UNMAPPED = 2'b00;
`endif

  system_controller_axil_regs dut (
    .s00_axi_aclk(clk), .s00_axi_areset(rst),
    .s00_axi_awaddr(awaddr), .s00_axi_awprot(awprot), .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
    .s00_axi_wdata(wdata), .s00_axi_wstrb(wstrb), .s00_axi_wvalid(wvalid), .s00_axi_wready(wready),
    .s00_axi_bresp(bresp), .s00_axi_bvalid(bvalid), .s00_axi_bready(bready),
    .s00_axi_araddr(araddr), .s00_axi_arprot(arprot), .s00_axi_arvalid(arvalid), .s00_axi_arready(arready),
    .s00_axi_rdata(rdata), .s00_axi_rresp(rresp), .s00_axi_rvalid(rvalid), .s00_axi_rready(rready),
    .reg0(r0), .reg1(r1), .reg2(r2), .reg3(r3), .reg_wr_pulse(pulse)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old_v, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] m;
    m = old_v;
    for (int b = 0; b < 4; b++)
      if (s[b]) m = (m & ~(32'hFF << (8*b))) | (d & (32'hFF << (8*b)));
    return m;
  endfunction

  function automatic bit mapped(input logic [4:0] a);
    return a < 5'd16;
  endfunction

  task automatic chk_regs(input string tag);
    chk({tag, "_reg0"}, r0, model_regs[0]);
    chk({tag, "_reg1"}, r1, model_regs[1]);
    chk({tag, "_reg2"}, r2, model_regs[2]);
    chk({tag, "_reg3"}, r3, model_regs[3]);
  endtask

  // lead > 0: W presented that many cycles before AW; lead < 0: AW first.
  task automatic axi_write(input logic [4:0] a, input logic [31:0] d, input logic [3:0] s,
                           input int lead, input int bdelay);
    int aw_start, w_start, cyc;
    bit aw_done, w_done, aw_hs, w_hs;
    logic [3:0] exp_pulse;
    aw_start = (lead > 0) ? lead : 0;
    w_start  = (lead < 0) ? -lead : 0;
    aw_done = 0; w_done = 0; cyc = 0;
    awaddr = a; wdata = d; wstrb = s;
    while (!(aw_done && w_done) && cyc < 20) begin
      awvalid = !aw_done && (cyc >= aw_start);
      wvalid  = !w_done && (cyc >= w_start);
      #1;
      aw_hs = awvalid && awready;
      w_hs  = wvalid && wready;
      if (awvalid && cyc == aw_start) chk("awready_first", 32'(awready), 32'd1);
      if (wvalid && cyc == w_start)   chk("wready_first", 32'(wready), 32'd1);
      @(posedge clk); #1;
      if (aw_hs) aw_done = 1;
      if (w_hs)  w_done = 1;
      cyc++;
    end
    awvalid = 0; wvalid = 0;
    chk("hs_done", 32'({aw_done, w_done}), 32'd3);
    chk("bvalid_before_commit", 32'(bvalid), 32'd0);
    @(posedge clk); #1;
    exp_pulse = mapped(a) ? (4'b0001 << ((a >> 2) & 5'd3)) : 4'b0000;
    if (mapped(a)) model_regs[(a >> 2) & 5'd3] = merge(model_regs[(a >> 2) & 5'd3], d, s);
    chk("bvalid_commit", 32'(bvalid), 32'd1);
    chk("bresp", 32'(bresp), mapped(a) ? 32'd0 : 32'(EXP_UNMAPPED));
    chk("wr_pulse", 32'(pulse), 32'(exp_pulse));
    chk_regs("wr");
    for (int k = 0; k < bdelay; k++) begin
      awvalid = 1;
      #1;
      chk("awready_blocked", 32'(awready), 32'd0);
      awvalid = 0;
      @(posedge clk); #1;
      chk("bvalid_held", 32'(bvalid), 32'd1);
      chk("bresp_stable", 32'(bresp), mapped(a) ? 32'd0 : 32'(EXP_UNMAPPED));
      chk("wr_pulse_one_cycle", 32'(pulse), 32'd0);
    end
    bready = 1;
    @(posedge clk); #1;
    bready = 0;
    chk("bvalid_cleared", 32'(bvalid), 32'd0);
  endtask

  task automatic axi_read(input logic [4:0] a, input int rdelay, output logic [31:0] got);
    logic [31:0] exp_d;
    exp_d = mapped(a) ? model_regs[(a >> 2) & 5'd3] : 32'd0;
    araddr = a; arvalid = 1;
    #1;
    chk("arready", 32'(arready), 32'd1);
    @(posedge clk); #1;
    arvalid = 0;
    chk("rvalid", 32'(rvalid), 32'd1);
    chk("rdata", rdata, exp_d);
    chk("rresp", 32'(rresp), mapped(a) ? 32'd0 : 32'(EXP_UNMAPPED));
    got = rdata;
    for (int k = 0; k < rdelay; k++) begin
      arvalid = 1;
      #1;
      chk("arready_blocked", 32'(arready), 32'd0);
      arvalid = 0;
      @(posedge clk); #1;
      chk("rvalid_held", 32'(rvalid), 32'd1);
      chk("rdata_held", rdata, exp_d);
    end
    rready = 1;
    @(posedge clk); #1;
    rready = 0;
    chk("rvalid_cleared", 32'(rvalid), 32'd0);
  endtask

  initial begin
    logic [31:0] got, old_v;
    logic [4:0]  a;
    for (int i = 0; i < 4; i++) model_regs[i] = '0;

    // Reset state, with valids driven to show readies stay low.
    #1 rst = 1;
    awvalid = 1; wvalid = 1; arvalid = 1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_awready", 32'(awready), 32'd0);
    chk("rst_wready", 32'(wready), 32'd0);
    chk("rst_arready", 32'(arready), 32'd0);
    chk("rst_bvalid", 32'(bvalid), 32'd0);
    chk("rst_rvalid", 32'(rvalid), 32'd0);
    chk("rst_resp", 32'({bresp, rresp}), 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_pulse", 32'(pulse), 32'd0);
    chk_regs("rst");
    awvalid = 0; wvalid = 0; arvalid = 0;
    rst = 0;

    // Basic full write then read.
    axi_write(5'h00, 32'h0101FFFF, 4'hF, 0, 0);
    axi_read(5'h00, 0, got);
    chk("basic_read", got, 32'h0101FFFF);

    // Partial strobe.
    axi_write(5'h04, 32'habcd0001, 4'hF, 0, 1);
    axi_write(5'h04, 32'hdead0011, 4'b0011, 0, 0);
    axi_read(5'h04, 2, got);
    chk("strobe_read", got, 32'habcd0011);

    // W well ahead of AW, response back-pressured.
    axi_write(5'h08, 32'h12345678, 4'hF, 3, 5);
    axi_write(5'h08, 32'h9abcdef0, 4'h0, -2, 0);
    axi_read(5'h08, 0, got);
    chk("zero_strb_read", got, 32'h12345678);

    // Read colliding with a commit on the same edge returns the old value.
    old_v = model_regs[3];
    awaddr = 5'h0C; wdata = 32'hbeef0011; wstrb = 4'hF;
    awvalid = 1; wvalid = 1;
    #1;
    chk("coll_aw_w_ready", 32'({awready, wready}), 32'd3);
    @(posedge clk); #1;
    awvalid = 0; wvalid = 0;
    araddr = 5'h0C; arvalid = 1;
    #1;
    chk("coll_arready", 32'(arready), 32'd1);
    @(posedge clk); #1;
    arvalid = 0;
    model_regs[3] = 32'hbeef0011;
    chk("coll_rvalid", 32'(rvalid), 32'd1);
    chk("coll_rdata_old", rdata, old_v);
    chk("coll_bvalid", 32'(bvalid), 32'd1);
    chk("coll_pulse", 32'(pulse), 32'h8);
    bready = 1; rready = 1;
    @(posedge clk); #1;
    bready = 0; rready = 0;
    chk("coll_cleared", 32'({bvalid, rvalid}), 32'd0);
    axi_read(5'h0C, 0, got);
    chk("coll_later_read", got, 32'hbeef0011);

    // Unmapped write and read.
    axi_write(5'h14, 32'hffffffff, 4'hF, 0, 0);
    axi_read(5'h14, 0, got);
    chk("unmapped_rdata", got, 32'd0);

    // Randomized mix.
    for (int it = 0; it < 60; it++) begin
      a = 5'($urandom_range(0, 31));
      if ($urandom_range(0, 1) == 1)
        axi_write(a, $urandom, 4'($urandom_range(0, 15)), $urandom_range(0, 6) - 3, $urandom_range(0, 2));
      else
        axi_read(a, $urandom_range(0, 2), got);
    end

    // Reset with AW held and W never sent.
    awaddr = 5'h00; awvalid = 1;
    #1;
    chk("mid_awready", 32'(awready), 32'd1);
    @(posedge clk); #1;
    awvalid = 0;
    #2 rst = 1;
    wvalid = 1; wdata = 32'h55555555; wstrb = 4'hF;
    #1;
    chk("mid_rst_wready", 32'(wready), 32'd0);
    @(posedge clk); #1;
    wvalid = 0;
    for (int i = 0; i < 4; i++) model_regs[i] = '0;
    chk_regs("mid_rst");
    rst = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_no_bvalid", 32'(bvalid), 32'd0);
    chk_regs("mid_after");
    axi_write(5'h04, 32'hcafef00d, 4'hF, 0, 0);
    axi_read(5'h04, 0, got);
    chk("post_rst_read", got, 32'hcafef00d);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
